es_periferico: RTL and testbench

- I/O responder on the CPU's input/output port bus; it answers the CPU's I/O reads and writes.
- Decodes a 2-bit port address and serves four registers: RX data, status, RX count and scratch.
- Inbound external bytes arrive over a valid/ready handshake and are buffered in an RX FIFO.
- CPU writes drive a single-entry TX holding register presented on an outbound valid/ready handshake.

---
 rtl/es_periferico.sv | 142 ++++++++++++++
 tb/tb_es_periferico.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/es_periferico.sv
// I/O-port responder: CPU reads/writes four registers (RX data, status, RX count, scratch),
// with an inbound byte FIFO and a single-entry outbound holding register.
module es_periferico #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   cpu_addr,
   input  logic         cpu_wr,
   input  logic         cpu_rd,
   input  logic [W-1:0] cpu_wdata,
   output logic [W-1:0] cpu_rdata,
   input  logic [W-1:0] ext_in_data,
   input  logic         ext_in_valid,
   output logic         ext_in_ready,
   output logic [W-1:0] ext_out_data,
   output logic         ext_out_valid,
   input  logic         ext_out_ready
);

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_COUNT   = 2'd2;
   localparam logic [1:0] ADDR_SCRATCH = 2'd3;
   localparam logic [AW:0] DEPTH_CNT   = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [AW:0]   count_reg;
   logic [AW:0]   count_next;
   logic          underflow_reg;
   logic          underflow_next;
   logic          tx_drop_reg;
   logic          tx_drop_next;
   logic [W-1:0]  scratch_reg;

   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          pop;
   logic          rd_data;
   logic          wr_data;
   logic          wr_status;
   logic          tx_handshake;
   logic          tx_load;
   logic          tx_reject;
   logic          underflow_set;
   logic [W-1:0]  status_word;
   logic [W-1:0]  count_word;

   assign fifo_empty   = (count_reg == '0);
   assign fifo_full    = (count_reg == DEPTH_CNT);
   assign ext_in_ready = !fifo_full;

   assign rd_data   = cpu_rd && (cpu_addr == ADDR_DATA);
   assign wr_data   = cpu_wr && (cpu_addr == ADDR_DATA);
   assign wr_status = cpu_wr && (cpu_addr == ADDR_STATUS);

   // Readiness comes from the registered count, so a pop cannot free a slot for a push in the same cycle.
   assign push          = ext_in_valid && ext_in_ready;
   assign pop           = rd_data && !fifo_empty;
   assign underflow_set = rd_data && fifo_empty;

   assign tx_handshake = ext_out_valid && ext_out_ready;
   assign tx_load      = wr_data && (!ext_out_valid || ext_out_ready);
   assign tx_reject    = wr_data && ext_out_valid && !ext_out_ready;

   assign status_word = {{(W-5){1'b0}}, tx_drop_reg, underflow_reg, ext_out_valid,
                         fifo_full, !fifo_empty};
   assign count_word  = {{(W-AW-1){1'b0}}, count_reg};

   always_comb begin
      cpu_rdata = '0;
      if (cpu_rd) begin
         case (cpu_addr)
            ADDR_DATA:    cpu_rdata = fifo_empty ? '0 : mem[rd_ptr_reg];
            ADDR_STATUS:  cpu_rdata = status_word;
            ADDR_COUNT:   cpu_rdata = count_word;
            ADDR_SCRATCH: cpu_rdata = scratch_reg;
            default:      cpu_rdata = '0;
         endcase
      end
   end

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Write-one-to-clear, with a same-cycle set taking priority over the clear.
   always_comb begin
      underflow_next = (underflow_reg && !(wr_status && cpu_wdata[3])) || underflow_set;
      tx_drop_next   = (tx_drop_reg   && !(wr_status && cpu_wdata[4])) || tx_reject;
   end

   // Storage has no reset: stale entries are never visible because reads are gated by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= ext_in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_reg    <= '0;
         wr_ptr_reg    <= '0;
         count_reg     <= '0;
         underflow_reg <= 1'b0;
         tx_drop_reg   <= 1'b0;
         scratch_reg   <= '0;
         ext_out_valid <= 1'b0;
         ext_out_data  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg     <= count_next;
         underflow_reg <= underflow_next;
         tx_drop_reg   <= tx_drop_next;
         if (cpu_wr && (cpu_addr == ADDR_SCRATCH)) begin
            scratch_reg <= cpu_wdata;
         end
         if (tx_load) begin
            ext_out_valid <= 1'b1;
            ext_out_data  <= cpu_wdata;
         end else if (tx_handshake) begin
            ext_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_es_periferico.sv
// Bench for es_periferico: directed test-plan sequences plus random traffic,
// all checked against a queue-based behavioural model of the register map.
module tb_es_periferico;

   localparam int W     = 8;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   cpu_addr;
   logic         cpu_wr;
   logic         cpu_rd;
   logic [W-1:0] cpu_wdata;
   logic [W-1:0] cpu_rdata;
   logic [W-1:0] ext_in_data;
   logic         ext_in_valid;
   logic         ext_in_ready;
   logic [W-1:0] ext_out_data;
   logic         ext_out_valid;
   logic         ext_out_ready;

   es_periferico #(.W(W), .DEPTH(DEPTH), .AW(2)) dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
      .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   logic [W-1:0] m_q [$];
   logic         m_tv;
   logic [W-1:0] m_td;
   logic         m_uf;
   logic         m_drop;
   logic [W-1:0] m_scratch;
   logic [W-1:0] obs_rdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_tv = 1'b0;
      m_td = '0;
      m_uf = 1'b0;
      m_drop = 1'b0;
      m_scratch = '0;
   endtask

   function automatic logic [W-1:0] model_rdata(input logic [1:0] a, input logic rd);
      logic [W-1:0] r;
      r = '0;
      if (rd) begin
         case (a)
            2'd0: r = (m_q.size() > 0) ? m_q[0] : '0;
            2'd1: r = W'({m_drop, m_uf, m_tv, (m_q.size() == DEPTH), (m_q.size() > 0)});
            2'd2: r = W'(m_q.size());
            default: r = m_scratch;
         endcase
      end
      return r;
   endfunction

   // One bus cycle: drive at negedge, check combinational outputs mid-cycle, update model at the edge.
   task automatic cyc(input logic [1:0] a, input logic rd, input logic wr, input logic [W-1:0] wd,
                      input logic iv, input logic [W-1:0] id, input logic ordy);
      logic   hs, can_push, ld;
      cpu_addr = a; cpu_rd = rd; cpu_wr = wr; cpu_wdata = wd;
      ext_in_valid = iv; ext_in_data = id; ext_out_ready = ordy;
      #2;
      check("rdata",     cpu_rdata,     model_rdata(a, rd));
      check("in_ready",  ext_in_ready,  m_q.size() < DEPTH);
      check("out_valid", ext_out_valid, m_tv);
      check("out_data",  ext_out_data,  m_td);
      obs_rdata = cpu_rdata;
      if (rd || wr)
         $display("t=%0t addr=%0d rd=%0b wr=%0b wdata=%02h rdata=%02h", $time, a, rd, wr, wd, cpu_rdata);
      @(posedge clk);
      hs       = m_tv && ordy;
      can_push = iv && (m_q.size() < DEPTH);
      if (rd && a == 2'd0) begin
         if (m_q.size() > 0) void'(m_q.pop_front());
         else m_uf = 1'b1;
      end else if (wr && a == 2'd1 && wd[3]) begin
         m_uf = 1'b0;
      end
      if (wr && a == 2'd1 && wd[4] && !(wr && a == 2'd0)) m_drop = 1'b0;
      if (can_push) m_q.push_back(id);
      ld = wr && a == 2'd0 && (!m_tv || ordy);
      if (wr && a == 2'd0 && m_tv && !ordy) m_drop = 1'b1;
      if (ld) begin
         m_tv = 1'b1;
         m_td = wd;
      end else if (hs) begin
         m_tv = 1'b0;
      end
      if (wr && a == 2'd3) m_scratch = wd;
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      cyc(2'd0, 1'b0, 1'b0, '0, 1'b0, '0, ordy);
   endtask

   initial begin
      logic [W-1:0] pat [4];
      reset = 1'b1;
      cpu_addr = '0; cpu_rd = 0; cpu_wr = 0; cpu_wdata = '0;
      ext_in_valid = 0; ext_in_data = '0; ext_out_ready = 0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset release
      idle(1'b0);
      cyc(2'd1, 1, 0, '0, 0, '0, 0); check("rst_status", obs_rdata, 8'h00);
      cyc(2'd2, 1, 0, '0, 0, '0, 0); check("rst_count",  obs_rdata, 8'h00);

      // Fill and drain
      pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
      for (int i = 0; i < 4; i++) cyc(2'd0, 0, 0, '0, 1, pat[i], 0);
      cyc(2'd1, 1, 0, '0, 1, 8'h55, 0); check("full_status", obs_rdata, 8'h03);
      check("full_ready", ext_in_ready, 1'b0);
      cyc(2'd2, 1, 0, '0, 0, '0, 0); check("full_count", obs_rdata, 8'h04);
      for (int i = 0; i < 4; i++) begin
         cyc(2'd0, 1, 0, '0, 0, '0, 0); check("drain", obs_rdata, pat[i]);
      end
      cyc(2'd0, 1, 0, '0, 0, '0, 0); check("empty_read", obs_rdata, 8'h00);
      cyc(2'd1, 1, 0, '0, 0, '0, 0); check("uf_set", obs_rdata[3], 1'b1);
      cyc(2'd1, 0, 1, 8'h08, 0, '0, 0);
      cyc(2'd1, 1, 0, '0, 0, '0, 0); check("uf_clr", obs_rdata[3], 1'b0);

      // Simultaneous push/pop at count 2, with pointer wrap over several rounds
      cyc(2'd0, 0, 0, '0, 1, 8'h01, 0);
      cyc(2'd0, 0, 0, '0, 1, 8'h02, 0);
      for (int i = 0; i < 3 * DEPTH; i++) cyc(2'd0, 1, 0, '0, 1, W'(8'h10 + i), 0);
      cyc(2'd2, 1, 0, '0, 0, '0, 0); check("pp_count", obs_rdata, 8'h02);
      for (int r = 0; r < 3; r++) begin
         while (m_q.size() < DEPTH) cyc(2'd0, 0, 0, '0, 1, W'($urandom), 0);
         while (m_q.size() > 0) cyc(2'd0, 1, 0, '0, 0, '0, 0);
      end

      // TX drop and back-to-back
      cyc(2'd0, 0, 1, 8'hA5, 0, '0, 0);
      cyc(2'd0, 0, 1, 8'h5A, 0, '0, 0);
      check("tx_hold", ext_out_data, 8'hA5);
      cyc(2'd1, 1, 0, '0, 0, '0, 0); check("tx_drop", obs_rdata[4], 1'b1);
      cyc(2'd0, 0, 1, 8'h77, 0, '0, 1);
      check("tx_b2b_valid", ext_out_valid, 1'b1);
      check("tx_b2b_data",  ext_out_data,  8'h77);
      idle(1'b1);
      cyc(2'd1, 0, 1, 8'h10, 0, '0, 0);

      // Scratch
      cyc(2'd3, 0, 1, 8'hC3, 0, '0, 0);
      cyc(2'd3, 1, 0, '0, 0, '0, 0); check("scratch", obs_rdata, 8'hC3);
      cyc(2'd3, 0, 0, '0, 0, '0, 0); check("rd_idle_zero", obs_rdata, 8'h00);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic [1:0] a;
         logic rd, wr;
         a  = 2'($urandom_range(0, 3));
         rd = ($urandom_range(0, 2) == 0);
         wr = ($urandom_range(0, 3) == 0);
         cyc(a, rd, wr, W'($urandom), ($urandom_range(0, 1) == 1), W'($urandom),
             ($urandom_range(0, 2) != 0));
      end

      // Mid-operation reset
      while (m_q.size() > 0) cyc(2'd0, 1, 0, '0, 0, '0, 1);
      idle(1'b1);
      for (int i = 0; i < 3; i++) cyc(2'd0, 0, 0, '0, 1, W'(8'h60 + i), 0);
      cyc(2'd0, 0, 1, 8'h9C, 0, '0, 0);
      check("pre_rst_valid", ext_out_valid, 1'b1);
      ext_in_valid = 0; ext_out_ready = 0; cpu_wr = 0; cpu_rd = 0;
      #3 reset = 1'b1;
      #1;
      check("async_valid", ext_out_valid, 1'b0);
      check("async_data",  ext_out_data,  8'h00);
      check("async_ready", ext_in_ready,  1'b1);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      cyc(2'd2, 1, 0, '0, 0, '0, 0); check("post_rst_count", obs_rdata, 8'h00);
      cyc(2'd1, 1, 0, '0, 0, '0, 0); check("post_rst_status", obs_rdata, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
